// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like memory port between an instruction
// fetch port and a data load/store port. One transaction in flight at a time:
// IDLE (grant) -> ADDR (mem_req until mem_addr_ok) -> DATA (wait mem_data_ok).
module sram_arbiter #(
  parameter int RR_MODE = 0   // 0: data has fixed priority, 1: round-robin on ties
) (
  input  logic        clk,
  input  logic        reset,
  // inst port (read only)
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // memory side
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state;
  logic        hold_wr;
  logic [1:0]  hold_size;
  logic [3:0]  hold_wstrb;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  logic        own_data;    // owner of the in-flight transaction: 1 = data port
  logic        last_data;   // last grant went to data (round-robin history)

  logic any_req, grant_data, gnt_fire, in_addr, xact_done;

  // Grant decision: data wins unless inst is alone, or round-robin says it
  // is inst's turn because data took the previous grant.
  assign any_req    = inst_req | data_req;
  assign grant_data = data_req & (~inst_req | (RR_MODE == 0) | ~last_data);

  // Everything observable is gated by reset so outputs read 0 while it is held,
  // even before the synchronous reset edge has landed in the state register.
  assign gnt_fire   = ~reset & (state == IDLE) & any_req;
  assign in_addr    = ~reset & (state == ADDR);
  assign xact_done  = ~reset & (state == DATA) & mem_data_ok;

  assign inst_addr_ok = gnt_fire & ~grant_data;
  assign data_addr_ok = gnt_fire &  grant_data;
  assign inst_data_ok = xact_done & ~own_data;
  assign data_data_ok = xact_done &  own_data;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;

  assign mem_req   = in_addr;
  assign mem_wr    = in_addr & hold_wr;
  assign mem_size  = in_addr ? hold_size  : 2'd0;
  assign mem_wstrb = in_addr ? hold_wstrb : 4'h0;
  assign mem_addr  = in_addr ? hold_addr  : 32'h0;
  assign mem_wdata = in_addr ? hold_wdata : 32'h0;

  // Transaction FSM: capture the granted request, then track the memory handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_wr    <= 1'b0;
      hold_size  <= 2'd0;
      hold_wstrb <= 4'h0;
      hold_addr  <= 32'h0;
      hold_wdata <= 32'h0;
      own_data   <= 1'b0;
      last_data  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          own_data  <= grant_data;
          last_data <= grant_data;
          if (grant_data) begin
            hold_wr    <= data_wr;
            hold_size  <= data_size;
            hold_wstrb <= data_wstrb;
            hold_addr  <= data_addr;
            hold_wdata <= data_wdata;
          end else begin
            // fetches are always full-word reads
            hold_wr    <= 1'b0;
            hold_size  <= 2'd2;
            hold_wstrb <= 4'h0;
            hold_addr  <= inst_addr;
            hold_wdata <= 32'h0;
          end
          state <= ADDR;
        end
        ADDR: if (mem_addr_ok) state <= DATA;
        DATA: if (mem_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one fixed-priority and one round-robin
// instance share stimulus; expected values are hand-computed per cycle.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [3:0]  data_wstrb = 4'h0;
  logic [31:0] data_addr = 32'h0, data_wdata = 32'h0;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  // fixed-priority instance outputs
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  // round-robin instance outputs
  logic        r_inst_addr_ok, r_inst_data_ok, r_data_addr_ok, r_data_data_ok;
  logic [31:0] r_inst_rdata, r_data_rdata;
  logic        r_mem_req, r_mem_wr;
  logic [1:0]  r_mem_size;
  logic [3:0]  r_mem_wstrb;
  logic [31:0] r_mem_addr, r_mem_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.RR_MODE(0)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  sram_arbiter #(.RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(r_inst_addr_ok),
    .inst_data_ok(r_inst_data_ok), .inst_rdata(r_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(r_data_addr_ok), .data_data_ok(r_data_data_ok), .data_rdata(r_data_rdata),
    .mem_req(r_mem_req), .mem_wr(r_mem_wr), .mem_size(r_mem_size), .mem_wstrb(r_mem_wstrb),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs change here, then #1 to settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset: outputs read 0 even with requests pending
    inst_req = 1'b1; data_req = 1'b1;
    tick(); tick();
    #1;
    chk("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
    chk("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'h0);
    chk("rst_mem_req",      {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr",     mem_addr, 32'h0);
    chk("rst_mem_size",     {30'b0, mem_size}, 32'h0);
    inst_req = 1'b0; data_req = 1'b0;
    tick();
    reset = 1'b0;

    // ---- inst read, T = grant cycle
    inst_req = 1'b1; inst_addr = 32'h1C000000; #1;
    chk("t0_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h1);
    chk("t0_data_addr_ok", {31'b0, data_addr_ok}, 32'h0);
    chk("t0_mem_req",      {31'b0, mem_req}, 32'h0);
    tick(); inst_req = 1'b0; #1;                                 // T+1
    chk("t1_mem_req",  {31'b0, mem_req}, 32'h1);
    chk("t1_mem_addr", mem_addr, 32'h1C000000);
    chk("t1_mem_wr",   {31'b0, mem_wr}, 32'h0);
    chk("t1_mem_size", {30'b0, mem_size}, 32'h2);
    chk("t1_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
    tick(); mem_addr_ok = 1'b1; #1;                              // T+2
    chk("t2_mem_req", {31'b0, mem_req}, 32'h1);
    tick(); mem_addr_ok = 1'b0; mem_rdata = 32'h02800C0C; #1;    // T+3, DATA
    chk("t3_mem_req",      {31'b0, mem_req}, 32'h0);
    chk("t3_inst_data_ok", {31'b0, inst_data_ok}, 32'h0);
    chk("t3_inst_rdata",   inst_rdata, 32'h0);
    tick(); mem_data_ok = 1'b1; #1;                              // T+4
    chk("t4_inst_data_ok", {31'b0, inst_data_ok}, 32'h1);
    chk("t4_inst_rdata",   inst_rdata, 32'h02800C0C);
    chk("t4_data_data_ok", {31'b0, data_data_ok}, 32'h0);
    chk("t4_data_rdata",   data_rdata, 32'h0);
    tick(); mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // ---- simultaneous requests, fixed priority: data write first
    inst_req = 1'b1; inst_addr = 32'h1C000004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h00001000; data_wdata = 32'hDEADBEEF; #1;
    chk("tie_data_addr_ok", {31'b0, data_addr_ok}, 32'h1);
    chk("tie_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
    tick();
    data_req = 1'b0; data_addr = 32'h00005555; data_wdata = 32'h0; data_wstrb = 4'h1;
    // stall in ADDR for 5 cycles; fields must hold, stray mem_data_ok ignored
    for (int i = 0; i < 5; i++) begin
      mem_data_ok = (i == 2); mem_rdata = (i == 2) ? 32'hBAD0BAD0 : 32'h0; #1;
      chk("stall_mem_req",   {31'b0, mem_req}, 32'h1);
      chk("stall_mem_wr",    {31'b0, mem_wr}, 32'h1);
      chk("stall_mem_addr",  mem_addr, 32'h00001000);
      chk("stall_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("stall_mem_wstrb", {28'b0, mem_wstrb}, 32'hF);
      chk("stall_oks", {28'b0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'h0);
      chk("stall_data_rdata", data_rdata, 32'h0);
      tick();
    end
    mem_data_ok = 1'b0; mem_rdata = 32'h0; mem_addr_ok = 1'b1; #1;
    chk("wr_mem_req", {31'b0, mem_req}, 32'h1);
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h12345678; #1;
    chk("wr_data_data_ok", {31'b0, data_data_ok}, 32'h1);
    chk("wr_data_rdata",   data_rdata, 32'h12345678);
    chk("wr_no_inst_grant", {31'b0, inst_addr_ok}, 32'h0);
    chk("wr_inst_data_ok",  {31'b0, inst_data_ok}, 32'h0);
    tick(); mem_data_ok = 1'b0; mem_rdata = 32'h0; #1;
    chk("after_wr_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h1);
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b1; #1;
    chk("i2_mem_addr", mem_addr, 32'h1C000004);
    chk("i2_mem_wr",   {31'b0, mem_wr}, 32'h0);
    chk("i2_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hAAAA5555; #1;
    chk("i2_inst_data_ok", {31'b0, inst_data_ok}, 32'h1);
    chk("i2_inst_rdata",   inst_rdata, 32'hAAAA5555);
    tick();
    // stray mem_data_ok in IDLE (no requests)
    mem_rdata = 32'h77777777; #1;
    chk("idle_stray_oks", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
    chk("idle_stray_rdata", inst_rdata | data_rdata, 32'h0);
    tick(); mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // ---- round-robin: reset history, both request continuously
    reset = 1'b1; tick(); reset = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C000100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h00002000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_data_grant", {31'b0, r_data_addr_ok}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_inst_grant", {31'b0, r_inst_addr_ok}, (k % 2 == 0) ? 32'h0 : 32'h1);
      chk("fp_data_grant", {31'b0, data_addr_ok}, 32'h1);
      tick(); mem_addr_ok = 1'b1; #1;
      chk("rr_mem_addr", r_mem_addr, (k % 2 == 0) ? 32'h00002000 : 32'h1C000100);
      tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h100 + k; #1;
      chk("rr_owner_ok", {30'b0, r_inst_data_ok, r_data_data_ok},
          (k % 2 == 0) ? 32'h1 : 32'h2);
      tick(); mem_data_ok = 1'b0; mem_rdata = 32'h0;
    end
    inst_req = 1'b0; data_req = 1'b0;

    // ---- reset during DATA aborts; stray mem_data_ok afterwards ignored
    tick();
    inst_req = 1'b1; inst_addr = 32'h1C000200;
    tick(); inst_req = 1'b0; mem_addr_ok = 1'b1;
    tick(); mem_addr_ok = 1'b0; reset = 1'b1; mem_rdata = 32'h55AA55AA; #1;
    chk("rstd_inst_data_ok", {31'b0, inst_data_ok}, 32'h0);
    chk("rstd_inst_rdata",   inst_rdata, 32'h0);
    tick(); reset = 1'b0; #1;
    chk("post_rst_mem_req", {31'b0, mem_req}, 32'h0);
    tick(); mem_data_ok = 1'b1; #1;
    chk("post_rst_stray_oks", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
    chk("post_rst_rdata", inst_rdata, 32'h0);
    tick(); mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C000008; #1;
    chk("post_rst_grant", {31'b0, inst_addr_ok}, 32'h1);
    tick(); inst_req = 1'b0; #1;
    chk("post_rst_mem_req2", {31'b0, mem_req}, 32'h1);
    chk("post_rst_mem_addr", mem_addr, 32'h1C000008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
